// File: rtl/fifo_read_arbiter_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO read arbiter.
//   state_t  - arbiter FSM state encoding (IDLE, ISSUE, WAIT, PRESENT)
//   next_ch  - channel successor with explicit wrap to zero
//   DEF_*    - default word width and FIFO read latency
package fifo_arb_pkg;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_READ_LATENCY = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;
   // Compare-and-zero so non-power-of-two channel counts wrap correctly
   function automatic int next_ch(input int ch, input int n);
      return (ch == n - 1) ? 0 : ch + 1;
   endfunction
endpackage

// File: rtl/fifo_read_arbiter_if.sv
// fifo_read_arbiter_if: FIFO-side and consumer-side signals of the read arbiter.
//   fifo_nonempty [N_CH]            per-channel nonempty flags
//   fifo_read     [N_CH]            per-channel read pulses (one-hot or zero)
//   fifo_data     [N_CH*DATA_WIDTH] flattened FIFO read data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready             output handshake
//   out_data      [DATA_WIDTH]      captured word
//   out_channel   [CH_WIDTH]        source channel of out_data
//   modport master: arbiter side; modport slave: FIFOs plus consumer side
interface fifo_read_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   localparam int CH_WIDTH = $clog2(N_CH);
   logic [N_CH-1:0]            fifo_nonempty;
   logic [N_CH-1:0]            fifo_read;
   logic [N_CH*DATA_WIDTH-1:0] fifo_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      out_data;
   logic [CH_WIDTH-1:0]        out_channel;
   modport master (
      input  fifo_nonempty, fifo_data, out_ready,
      output fifo_read, out_valid, out_data, out_channel
   );
   modport slave (
      output fifo_nonempty, fifo_data, out_ready,
      input  fifo_read, out_valid, out_data, out_channel
   );
endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req   [N] request vector
//   ptr   [W] channel searched first; search continues upward with wrap
//   found     any request set
//   idx   [W] first requesting channel at or after ptr
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);
   logic [W:0] c;
   // Walk offsets from farthest to nearest so the nearest hit overwrites
   always_comb begin
      found = |req;
      idx   = '0;
      c     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         c = {1'b0, ptr} + (W+1)'(i);
         c = (c >= (W+1)'(N)) ? c - (W+1)'(N) : c;
         if (req[c[W-1:0]]) idx = c[W-1:0];
      end
   end
endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin read scheduler sharing one consumer between N_CH FIFOs.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    fifo_read_arbiter_if.master (nonempty/read/data per FIFO, valid/ready output)
// One read is outstanding at a time: IDLE picks, ISSUE pulses fifo_read,
// WAIT covers READ_LATENCY, PRESENT holds the word until accepted.
// Define FIFO_ARB_PRIORITY_EN to make channel 0 strict priority over the rotation.
module fifo_read_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input logic                 clk,
   input logic                 reset,
   fifo_read_arbiter_if.master bus
);
   localparam int CH_WIDTH = $clog2(N_CH);
   localparam int CW       = $clog2(READ_LATENCY + 1);
   state_t                state, state_nx;
   logic [CH_WIDTH-1:0]   rr_ptr, grant, pick, out_channel;
   logic [CW-1:0]         cnt;
   logic [N_CH-1:0]       fifo_read;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  found, out_valid;
`ifdef FIFO_ARB_PRIORITY_EN
   logic                rr_found;
   logic [CH_WIDTH-1:0] rr_idx;
   // Channel 0 is masked out of the rotation and overrides it when set
   rr_pick #(.N(N_CH)) u_pick (
      .req   ({bus.fifo_nonempty[N_CH-1:1], 1'b0}),
      .ptr   (rr_ptr),
      .found (rr_found),
      .idx   (rr_idx)
   );
   assign found = bus.fifo_nonempty[0] | rr_found;
   assign pick  = bus.fifo_nonempty[0] ? '0 : rr_idx;
`else
   rr_pick #(.N(N_CH)) u_pick (
      .req   (bus.fifo_nonempty),
      .ptr   (rr_ptr),
      .found (found),
      .idx   (pick)
   );
`endif
   assign bus.fifo_read   = fifo_read;
   assign bus.out_valid   = out_valid;
   assign bus.out_data    = out_data;
   assign bus.out_channel = out_channel;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   // WAIT exits on the edge where the counter reaches zero, i.e. READ_LATENCY
   // cycles after the read-pulse edge, when the FIFO word is valid
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = found ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = (cnt == CW'(1)) ? PRESENT : WAIT;
         PRESENT: state_nx = bus.out_ready ? IDLE : PRESENT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         grant       <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         fifo_read   <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_channel <= '0;
      end else begin
         fifo_read <= '0;
         if (state == IDLE && found) begin
            grant     <= pick;
            fifo_read <= N_CH'(1) << pick;
         end
         if (state == ISSUE) cnt <= CW'(READ_LATENCY);
         if (state == WAIT) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               out_valid   <= 1'b1;
               out_data    <= bus.fifo_data[grant*DATA_WIDTH +: DATA_WIDTH];
               out_channel <= grant;
            end
         end
         if (state == PRESENT && bus.out_ready) begin
            out_valid <= 1'b0;
`ifdef FIFO_ARB_PRIORITY_EN
            if (grant != '0) rr_ptr <= CH_WIDTH'(next_ch(int'(grant), N_CH));
`else
            rr_ptr <= CH_WIDTH'(next_ch(int'(grant), N_CH));
`endif
         end
      end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed bench for fifo_read_arbiter (4-channel and 3-channel instances).
// FIFO models present word+channel exactly READ_LATENCY cycles after a read pulse and 16'hDEAD otherwise.
module tb_fifo_read_arbiter;
   import fifo_arb_pkg::*;
   typedef struct {
      logic [3:0]  ne;
      logic [15:0] word;
      logic [1:0]  ch;
      logic [15:0] data;
      int          gap;
   } vec_t;
`ifdef FIFO_ARB_PRIORITY_EN
   localparam logic [1:0] C3_A = 2'd0, C3_C = 2'd2;
`else
   localparam logic [1:0] C3_A = 2'd2, C3_C = 2'd1;
`endif
   logic        clk = 1'b0, reset = 1'b0;
   int          checks = 0, errors = 0, cyc = 0, pulse_bad = 0, pulse_seen = 0;
   logic [15:0] word4 = '0, word3 = '0;
   logic [3:0]  rd4_0 = '0, rd4_1 = '0, prev4 = '0;
   logic [2:0]  rd3_0 = '0, rd3_1 = '0, prev3 = '0;
   fifo_read_arbiter_if #(.N_CH(4), .DATA_WIDTH(16)) b4();
   fifo_read_arbiter_if #(.N_CH(3), .DATA_WIDTH(16)) b3();
   fifo_read_arbiter #(.N_CH(4), .DATA_WIDTH(16), .READ_LATENCY(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
   fifo_read_arbiter #(.N_CH(3), .DATA_WIDTH(16), .READ_LATENCY(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd4_0 <= b4.fifo_read;
      rd4_1 <= rd4_0;
      rd3_0 <= b3.fifo_read;
      rd3_1 <= rd3_0;
   end
   always_comb begin
      for (int k = 0; k < 4; k++) b4.fifo_data[k*16 +: 16] = rd4_1[k] ? word4 + 16'(k) : 16'hDEAD;
      for (int k = 0; k < 3; k++) b3.fifo_data[k*16 +: 16] = rd3_1[k] ? word3 + 16'(k) : 16'hDEAD;
   end
   // Read pulses must be one-hot and last a single cycle
   always @(negedge clk) begin
      if (b4.fifo_read != '0 || b3.fifo_read != '0) pulse_seen <= pulse_seen + 1;
      if ((b4.fifo_read != '0 && (!$onehot(b4.fifo_read) || prev4 != '0)) ||
          (b3.fifo_read != '0 && (!$onehot(b3.fifo_read) || prev3 != '0)))
         pulse_bad <= pulse_bad + 1;
      prev4 <= b4.fifo_read;
      prev3 <= b3.fifo_read;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask
   task automatic wait_valid(input bit sel3, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = sel3 ? b3.out_valid : b4.out_valid;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL valid_timeout: out_valid low for 40 cycles, required high (dut%0d)", sel3 ? 3 : 4);
      end
   endtask
   task automatic wait_read(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = b4.fifo_read != '0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read_timeout: fifo_read zero for 40 cycles, required a pulse");
      end
   endtask
   initial begin
      vec_t vq[$];
      bit   ok;
      int   last;
      b4.fifo_nonempty = '0;
      b4.out_ready     = 1'b1;
      b3.fifo_nonempty = '0;
      b3.out_ready     = 1'b1;
      vq.push_back('{4'b0100, 16'hBEED, 2'd2, 16'hBEEF, 0});
`ifdef FIFO_ARB_PRIORITY_EN
      vq.push_back('{4'b1111, 16'h1000, 2'd0, 16'h1000, 5});
      vq.push_back('{4'b1111, 16'h2000, 2'd0, 16'h2000, 5});
      vq.push_back('{4'b1111, 16'h3000, 2'd0, 16'h3000, 5});
      vq.push_back('{4'b1110, 16'h4000, 2'd3, 16'h4003, 5});
      vq.push_back('{4'b1110, 16'h5000, 2'd1, 16'h5001, 5});
      vq.push_back('{4'b1110, 16'h6000, 2'd2, 16'h6002, 5});
      vq.push_back('{4'b1110, 16'h7000, 2'd3, 16'h7003, 5});
      vq.push_back('{4'b1111, 16'h8000, 2'd0, 16'h8000, 5});
      vq.push_back('{4'b0001, 16'h9000, 2'd0, 16'h9000, 5});
`else
      vq.push_back('{4'b1111, 16'h1000, 2'd3, 16'h1003, 5});
      vq.push_back('{4'b1111, 16'h2000, 2'd0, 16'h2000, 5});
      vq.push_back('{4'b1111, 16'h3000, 2'd1, 16'h3001, 5});
      vq.push_back('{4'b1111, 16'h4000, 2'd2, 16'h4002, 5});
      vq.push_back('{4'b1111, 16'h5000, 2'd3, 16'h5003, 5});
      vq.push_back('{4'b1111, 16'h6000, 2'd0, 16'h6000, 5});
      vq.push_back('{4'b1111, 16'h7000, 2'd1, 16'h7001, 5});
      vq.push_back('{4'b1111, 16'h8000, 2'd2, 16'h8002, 5});
      vq.push_back('{4'b0011, 16'hA000, 2'd0, 16'hA000, 5});
      vq.push_back('{4'b0001, 16'hB000, 2'd0, 16'hB000, 5});
      vq.push_back('{4'b1000, 16'hC000, 2'd3, 16'hC003, 5});
      vq.push_back('{4'b0110, 16'hD000, 2'd1, 16'hD001, 5});
      vq.push_back('{4'b0110, 16'hE000, 2'd2, 16'hE002, 5});
      vq.push_back('{4'b0110, 16'hF000, 2'd1, 16'hF001, 5});
`endif
      repeat (3) @(negedge clk);
      chk("reset_state4", {b4.out_valid, b4.fifo_read, b4.out_channel, b4.out_data}, '0);
      chk("reset_state3", {b3.out_valid, b3.fifo_read, b3.out_channel, b3.out_data}, '0);
      reset = 1'b1;
      last  = cyc;
      foreach (vq[i]) begin
         b4.fifo_nonempty = vq[i].ne;
         word4            = vq[i].word;
         wait_valid(1'b0, ok);
         if (vq[i].gap != 0) chk($sformatf("v%0d_gap", i), cyc - last, vq[i].gap);
         last = cyc;
         chk($sformatf("v%0d_channel", i), b4.out_channel, vq[i].ch);
         chk($sformatf("v%0d_data", i), b4.out_data, vq[i].data);
      end
      @(negedge clk);
      // Backpressure: word and channel must hold, no reads issued
      b4.out_ready     = 1'b0;
      b4.fifo_nonempty = 4'b0100;
      word4            = 16'h5550;
      wait_valid(1'b0, ok);
      chk("bp_channel", b4.out_channel, 2'd2);
      chk("bp_data", b4.out_data, 16'h5552);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) word4 = 16'h7770;
         chk($sformatf("bp_hold%0d", i), {b4.out_valid, b4.fifo_read, b4.out_channel, b4.out_data},
             {1'b1, 4'b0000, 2'd2, 16'h5552});
      end
      word4        = 16'h6660;
      b4.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_single_handshake", b4.out_valid, 1'b0);
      wait_valid(1'b0, ok);
      chk("bp_next_channel", b4.out_channel, 2'd2);
      chk("bp_next_data", b4.out_data, 16'h6662);
      b4.fifo_nonempty = '0;
      @(negedge clk);
      // Asynchronous reset while presenting
      b4.out_ready     = 1'b0;
      b4.fifo_nonempty = 4'b1000;
      word4            = 16'h1110;
      wait_valid(1'b0, ok);
      chk("pre_reset_channel", b4.out_channel, 2'd3);
      chk("pre_reset_data", b4.out_data, 16'h1113);
      reset = 1'b0;
      #1;
      chk("async_reset_outputs", {b4.out_valid, b4.out_channel, b4.out_data}, '0);
      @(negedge clk);
      reset            = 1'b1;
      b4.out_ready     = 1'b1;
      b4.fifo_nonempty = 4'b1010;
      word4            = 16'h2220;
      wait_read(ok);
      chk("grant_after_reset", b4.fifo_read, 4'b0010);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_in_wait", {b4.fifo_read, b4.out_valid}, '0);
      @(negedge clk);
      reset = 1'b1;
      wait_read(ok);
      chk("regrant_after_reset", b4.fifo_read, 4'b0010);
      wait_valid(1'b0, ok);
      chk("reset_word_channel", b4.out_channel, 2'd1);
      chk("reset_word_data", b4.out_data, 16'h2221);
      b4.fifo_nonempty = '0;
      @(negedge clk);
      // Three-channel wrap
      b3.fifo_nonempty = 3'b010;
      word3            = 16'h3330;
      wait_valid(1'b1, ok);
      chk("w3_a_channel", b3.out_channel, 2'd1);
      chk("w3_a_data", b3.out_data, 16'h3331);
      b3.fifo_nonempty = 3'b101;
      word3            = 16'h4440;
      wait_valid(1'b1, ok);
      chk("w3_b_channel", b3.out_channel, C3_A);
      chk("w3_b_data", b3.out_data, 16'h4440 + 16'(C3_A));
      b3.fifo_nonempty = 3'b001;
      word3            = 16'h5550;
      wait_valid(1'b1, ok);
      chk("w3_c_channel", b3.out_channel, 2'd0);
      chk("w3_c_data", b3.out_data, 16'h5550);
      b3.fifo_nonempty = 3'b110;
      word3            = 16'h6660;
      wait_valid(1'b1, ok);
      chk("w3_d_channel", b3.out_channel, C3_C);
      chk("w3_d_data", b3.out_data, 16'h6660 + 16'(C3_C));
      b3.fifo_nonempty = '0;
      repeat (2) @(negedge clk);
      chk("read_pulse_shape", pulse_bad, 0);
      chk("read_pulses_seen", pulse_seen >= 20, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
